ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the imem responder.
- Holds the fetch PC and drives iaddr, then captures idata in the same cycle because imem is combinational.
- Buffers {pc, instr} pairs in a 2-entry queue and delivers them to decode over a valid/ready handshake.
- Handles control-flow redirects from execute and traps misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- QDEPTH, 2, fetch queue entries; only 2 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- iaddr  output  [MSB:LSB]  byte address to imem; always equals fetch_pc
- idata  input  [MSB:LSB]  instruction word from imem, valid in the same cycle as iaddr
- redirect_valid  input  1  branch/jump taken; single-cycle pulse
- redirect_pc  input  [MSB:LSB]  redirect target byte address
- if_valid  output  1  head queue entry is valid
- if_ready  input  1  decode accepts the head entry
- if_instr  output  [MSB:LSB]  head instruction word
- if_pc  output  [MSB:LSB]  PC of the head instruction
- misalign_err  output  1  sticky misaligned-redirect flag

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - fetch_pc = RESET_PC, so iaddr = RESET_PC.
  - Queue empty, so if_valid = 0.
  - if_instr = 0, if_pc = 0, misalign_err = 0, state = RUN.
- States are RUN and HALT.
- RUN, no redirect:
  - pop = if_valid & if_ready.
  - push = (count < QDEPTH) | pop.
  - On push: the entry {fetch_pc, idata} is written at the tail and fetch_pc <= fetch_pc + 4.
  - Simultaneous push and pop leaves count unchanged; ordering stays FIFO.
  - Queue full and no pop: no push, fetch_pc holds, iaddr is stable, no duplicate or skipped instruction.
- Latency:
  - First push happens on the first rising edge after rst deasserts.
  - if_valid rises on that edge with if_pc = RESET_PC.
  - Steady-state throughput is 1 instruction per cycle while if_ready = 1.
- fetch_pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, with no error.
- if_instr and if_pc:
  - Driven from the queue head.
  - Held stable while if_valid = 1 and if_ready = 0.
  - Hold their last value when the queue is empty.
- Redirect in RUN:
  - On the edge with redirect_valid = 1, the queue is flushed (count <= 0), the push is suppressed, and any pop is irrelevant.
  - If redirect_pc[1:0] == 0: fetch_pc <= redirect_pc and state stays RUN.
  - The next cycle has iaddr = redirect_pc and if_valid = 0.
  - The target instruction appears one edge later, giving a 1-cycle bubble.
  - If redirect_pc[1:0] != 0: misalign_err <= 1, state <= HALT, fetch_pc holds.
- HALT:
  - No push; queue stays empty, so if_valid = 0.
  - redirect_valid is ignored.
  - misalign_err stays 1; only rst exits HALT.
- Back-to-back redirects: each one flushes again; the last redirect's target is fetched.
- Reset asserted mid-operation:
  - Immediately forces all reset values, regardless of clk.
  - Queue contents are discarded, as is any pending handshake.
- Misaligned RESET_PC is a configuration error; an elaboration-time assertion flags it.

Decomposition:
- Package parameters (existing): reuse MSB and LSB, and add:
  - INSTR_BYTES = 4
  - typedef enum logic {RUN, HALT} fetch_state_t
  - typedef struct packed {logic [MSB:LSB] pc; logic [MSB:LSB] instr;} fetch_entry_t
- Sub-module fetch_queue:
  - 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: clk, rst, push, pop, flush, wdata, rdata, count, empty, full.
  - flush has priority over push.
- ifetch_unit contains the PC register, the state register, push/pop logic and the alignment check.

Test Plan:
- Reset release with if_ready = 1 and a memory image holding word k = 32'h1000_0000+k:
  - During reset: iaddr = 0, if_valid = 0.
  - After release: consecutive cycles show if_pc = 0,4,8,12 with if_instr = 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003.
- Backpressure: hold if_ready = 0 from reset:
  - Queue fills to 2 entries (pc 0, 4) and iaddr holds at 8.
  - When if_ready returns to 1, if_pc = 0, 4, 8 follow with no gap and no duplicate.
- Redirect while the queue is full (pc 8, 12 queued), redirect_valid = 1 with redirect_pc = 32'h100:
  - Next cycle: if_valid = 0 and iaddr = 32'h100.
  - Following cycle: if_pc = 32'h100; pc 8 and 12 are never accepted.
- Misaligned redirect to 32'h102:
  - misalign_err = 1 and if_valid = 0 permanently.
  - A later redirect to 32'h200 is ignored.
  - Pulsing rst clears misalign_err and restarts at RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC with if_ready = 1 -> if_pc sequence 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, with misalign_err = 0.
- Asynchronous reset mid-stream: assert rst between clock edges while if_valid = 1 -> if_valid, if_pc and if_instr go to 0 and iaddr goes to RESET_PC before the next clk edge.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared widths, fetch states and queue entry type for the instruction fetch slice.
// Revision 1.0
`default_nettype none

package ifetch_unit_pkg;

  localparam int MSB = 31;
  localparam int LSB = 0;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [MSB:LSB] pc;
    logic [MSB:LSB] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr}; slot 0 is always the head so rdata holds when empty.
// Revision 1.0
`default_nettype none

module fetch_queue
  import ifetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = pop & (r_count != 2'd0);
  assign w_do_push = push & ((r_count != 2'd2) | w_do_pop);

  // Flushing only clears the count, so the head slot keeps presenting the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else if (w_do_pop && w_do_push) begin
      if (r_count == 2'd2) begin
        r_head <= r_tail;
        r_tail <= wdata;
      end else begin
        r_head <= wdata;
      end
    end else if (w_do_pop) begin
      if (r_count == 2'd2) begin
        r_head <= r_tail;
      end
      r_count <= r_count - 2'd1;
    end else if (w_do_push) begin
      if (r_count == 2'd0) begin
        r_head <= wdata;
      end else begin
        r_tail <= wdata;
      end
      r_count <= r_count + 2'd1;
    end
  end

  assign rdata = r_head;
  assign count = r_count;
  assign empty = (r_count == 2'd0);
  assign full  = (r_count == 2'd2);

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC sequencing against a combinational imem, redirect handling and misalignment trap.
// Revision 1.0
`default_nettype none

module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [MSB:LSB] RESET_PC = 32'h0000_0000,
  parameter int             QDEPTH   = 2
) (
  input  logic           clk,
  input  logic           rst,
  output logic [MSB:LSB] iaddr,
  input  logic [MSB:LSB] idata,
  input  logic           redirect_valid,
  input  logic [MSB:LSB] redirect_pc,
  output logic           if_valid,
  input  logic           if_ready,
  output logic [MSB:LSB] if_instr,
  output logic [MSB:LSB] if_pc,
  output logic           misalign_err
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("ifetch_unit: RESET_PC must be word aligned");
  end

  if (QDEPTH != 2) begin : g_bad_qdepth
    $error("ifetch_unit: only QDEPTH = 2 is supported");
  end

  fetch_state_t   r_state;
  logic [MSB:LSB] r_fetch_pc;
  logic           r_misalign_err;

  fetch_entry_t   w_wdata;
  fetch_entry_t   w_rdata;
  logic [1:0]     w_count;
  logic           w_empty;
  logic           unused_full;
  logic           w_run;
  logic           w_redirect;
  logic           w_pop;
  logic           w_push;
  logic           w_flush;

  assign w_run      = (r_state == RUN);
  assign w_redirect = w_run & redirect_valid;
  assign w_pop      = if_valid & if_ready;
  assign w_push     = w_run & ~redirect_valid & ((w_count < 2'(QDEPTH)) | w_pop);
  assign w_flush    = w_redirect;

  assign w_wdata.pc    = r_fetch_pc;
  assign w_wdata.instr = idata;

  // Misaligned targets halt with fetch_pc frozen; only reset leaves HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_fetch_pc     <= RESET_PC;
      r_misalign_err <= 1'b0;
    end else if (w_redirect) begin
      if (redirect_pc[1:0] == 2'b00) begin
        r_fetch_pc <= redirect_pc;
      end else begin
        r_misalign_err <= 1'b1;
        r_state        <= HALT;
      end
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + (MSB - LSB + 1)'(INSTR_BYTES);
    end
  end

  fetch_queue u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .count (w_count),
    .empty (w_empty),
    .full  (unused_full)
  );

  assign iaddr        = r_fetch_pc;
  assign if_valid     = ~w_empty;
  assign if_pc        = w_rdata.pc;
  assign if_instr     = w_rdata.instr;
  assign misalign_err = r_misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit against a combinational memory image.
// Revision 1.0
`default_nettype none

module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  int checks;
  int failures;

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  // Memory image: word k holds 32'h1000_0000 + k.
  assign idata = 32'h1000_0000 + (iaddr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, instr);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    step();
    step();
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);

    // Streaming with if_ready = 1
    rst = 1'b0;
    step();
    check_head("s0", 32'h0, 32'h1000_0000);
    check("s0_iaddr", iaddr, 32'h4);
    step();
    check_head("s1", 32'h4, 32'h1000_0001);
    step();
    check_head("s2", 32'h8, 32'h1000_0002);
    step();
    check_head("s3", 32'hC, 32'h1000_0003);

    // Backpressure from reset
    rst      = 1'b1;
    if_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_head("bp0", 32'h0, 32'h1000_0000);
    check("bp0_iaddr", iaddr, 32'h4);
    step();
    check("bp1_iaddr", iaddr, 32'h8);
    step();
    check_head("bp2", 32'h0, 32'h1000_0000);
    check("bp2_iaddr", iaddr, 32'h8);
    if_ready = 1'b1;
    step();
    check_head("bp3", 32'h4, 32'h1000_0001);
    check("bp3_iaddr", iaddr, 32'hC);
    step();
    check_head("bp4", 32'h8, 32'h1000_0002);
    if_ready = 1'b0;
    step();
    check_head("bp5", 32'h8, 32'h1000_0002);
    check("bp5_iaddr", iaddr, 32'h10);

    // Redirect with pc 8 and 12 queued
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("rd_valid", {31'd0, if_valid}, 32'd0);
    check("rd_iaddr", iaddr, 32'h100);
    step();
    check_head("rd1", 32'h100, 32'h1000_0040);
    step();
    check_head("rd2", 32'h104, 32'h1000_0041);

    // Misaligned redirect traps and halts
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_valid", {31'd0, if_valid}, 32'd0);
    check("mis_iaddr", iaddr, 32'h108);
    step();
    check("mis_valid2", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    step();
    check("halt_iaddr", iaddr, 32'h108);
    check("halt_valid", {31'd0, if_valid}, 32'd0);
    check("halt_err", {31'd0, misalign_err}, 32'd1);
    rst = 1'b1;
    #2;
    check("halt_rst_err", {31'd0, misalign_err}, 32'd0);
    check("halt_rst_iaddr", iaddr, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_head("restart", 32'h0, 32'h1000_0000);

    // Wrap past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_valid", {31'd0, if_valid}, 32'd0);
    check("wr_iaddr", iaddr, 32'hFFFF_FFFC);
    step();
    check_head("wr0", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
    step();
    check_head("wr1", 32'h0000_0000, 32'h1000_0000);
    step();
    check_head("wr2", 32'h0000_0004, 32'h1000_0001);
    check("wr_err", {31'd0, misalign_err}, 32'd0);

    // Back-to-back redirects: last target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    check("bb_valid", {31'd0, if_valid}, 32'd0);
    check("bb_iaddr", iaddr, 32'h300);
    step();
    check_head("bb0", 32'h300, 32'h1000_00C0);
    step();
    check_head("bb1", 32'h304, 32'h1000_00C1);

    // Asynchronous reset between clock edges
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_pc", if_pc, 32'h0);
    check("ar_instr", if_instr, 32'h0);
    check("ar_iaddr", iaddr, 32'h0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
